// File: rtl/brush_ctrl.sv
// Square brush stamp / full-canvas clear sequencer.
// Emits one pixel-store write per cycle and a one-cycle done pulse.
module brush_ctrl #(
  parameter int CANVAS = 200,
  parameter int MAXR   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       stampReq,
  input  logic       clearReq,
  input  logic [7:0] cx,
  input  logic [7:0] cy,
  input  logic [1:0] radius,
  input  logic [2:0] color,
  output logic       brush,
  output logic [7:0] wx,
  output logic [7:0] wy,
  output logic [2:0] newColor,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    STAMP,
    CLEAR,
    DONE
  } state_e;

  localparam logic [1:0] RMAX =
    (MAXR > 3) ? 2'd3 : 2'(MAXR);
  localparam logic signed [9:0] CMAX =
    10'(CANVAS);
  localparam logic [7:0] LAST = 8'(CANVAS - 1);

  state_e     state_q;
  logic [7:0] cx_q, cy_q;
  logic [1:0] r_q;
  logic [2:0] col_q;
  logic [2:0] ox_q, oy_q;

  logic [1:0] r_in;
  logic [7:0] bcx, bcy;
  logic [1:0] br;
  logic [2:0] span;
  logic [2:0] ox_d, oy_d;
  logic       last_pt;
  logic signed [9:0] px, py;
  logic       inb;

  assign r_in = (radius > RMAX) ? RMAX : radius;
  assign busy = (state_q != IDLE);

  // Next scan point: first point when idle, else advance offsets.
  always_comb begin
    bcx  = cx_q;
    bcy  = cy_q;
    br   = r_q;
    ox_d = 3'd0;
    oy_d = 3'd0;
    if (state_q == IDLE) begin
      bcx = cx;
      bcy = cy;
      br  = r_in;
    end
    span = {br, 1'b0};
    if (state_q != IDLE) begin
      if (ox_q == span) begin
        oy_d = oy_q + 3'd1;
      end else begin
        ox_d = ox_q + 3'd1;
        oy_d = oy_q;
      end
    end
    last_pt = (ox_q == span) && (oy_q == span);
    px = $signed({2'b00, bcx})
       - $signed({8'b0, br})
       + $signed({7'b0, ox_d});
    py = $signed({2'b00, bcy})
       - $signed({8'b0, br})
       + $signed({7'b0, oy_d});
    inb = !px[9] && !py[9]
       && (px < CMAX) && (py < CMAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cx_q     <= 8'd0;
      cy_q     <= 8'd0;
      r_q      <= 2'd0;
      col_q    <= 3'd0;
      ox_q     <= 3'd0;
      oy_q     <= 3'd0;
      brush    <= 1'b0;
      wx       <= 8'd0;
      wy       <= 8'd0;
      newColor <= 3'd0;
      done     <= 1'b0;
    end else begin
      brush <= 1'b0;
      done  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clearReq) begin
            state_q  <= CLEAR;
            col_q    <= color;
            brush    <= 1'b1;
            wx       <= 8'd0;
            wy       <= 8'd0;
            newColor <= color;
          end else if (stampReq) begin
            state_q <= STAMP;
            cx_q    <= cx;
            cy_q    <= cy;
            r_q     <= r_in;
            col_q   <= color;
            ox_q    <= 3'd0;
            oy_q    <= 3'd0;
            if (inb) begin
              brush    <= 1'b1;
              wx       <= px[7:0];
              wy       <= py[7:0];
              newColor <= color;
            end
          end
        end
        STAMP: begin
          if (last_pt) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            ox_q <= ox_d;
            oy_q <= oy_d;
            if (inb) begin
              brush    <= 1'b1;
              wx       <= px[7:0];
              wy       <= py[7:0];
              newColor <= col_q;
            end
          end
        end
        CLEAR: begin
          if (wx == LAST && wy == LAST) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            brush <= 1'b1;
            if (wx == LAST) begin
              wx <= 8'd0;
              wy <= wy + 8'd1;
            end else begin
              wx <= wx + 8'd1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
